// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, opcode encodings and forwarding latencies for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned CNT_W        = 2;
    localparam int unsigned STALL_CNT_W  = 32;
    localparam int unsigned LOAD_LAT_DEF = 1;
    localparam int unsigned ALU_LAT_DEF  = 0;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Bubbles before a new result can be forwarded; load is only looked at when jal is low.
    function automatic logic [CNT_W-1:0] fwd_lat(input logic jal, input logic load,
                                                 input int unsigned load_lat,
                                                 input int unsigned alu_lat);
        if (jal)
            return CNT_W'(alu_lat);
        else if (load)
            return CNT_W'(load_lat);
        else
            return CNT_W'(alu_lat);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue, writeback and scoreboard status signals between decode and the scoreboard.
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic                         issue_valid_i;
    logic [REG_ADDR_W-1:0]        rd_i;
    logic [REG_ADDR_W-1:0]        rs1_i;
    logic [REG_ADDR_W-1:0]        rs2_i;
    logic                         rs1_used_i;
    logic                         rs2_used_i;
    logic                         reg_write_i;
    logic                         load_i;
    logic                         jal_i;
    logic                         flush_i;
    logic                         wb_valid_i;
    logic [REG_ADDR_W-1:0]        wb_rd_i;
    logic                         stall_o;
    logic [NUM_REGS-1:0]          pending_o;
    logic [STALL_CNT_W-1:0]       stall_cnt_o;

    modport master (
        output issue_valid_i, rd_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i,
        output reg_write_i, load_i, jal_i, flush_i, wb_valid_i, wb_rd_i,
        input  stall_o, pending_o, stall_cnt_o
    );

    modport slave (
        input  issue_valid_i, rd_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i,
        input  reg_write_i, load_i, jal_i, flush_i, wb_valid_i, wb_rd_i,
        output stall_o, pending_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's scoreboard slot: forwarding countdown plus uncommitted-write flag.
module sb_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [CNT_W-1:0] lat,
    input  logic             wb_clr,
    output logic             busy,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;

    // Allocation reloads the countdown and wins over both decrement and writeback clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (alloc) begin
            cnt     <= lat;
            pending <= 1'b1;
        end else begin
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (wb_clr)
                pending <= 1'b0;
        end
    end

    // Result not yet forwardable while the countdown is running.
    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard for ID-stage RAW hazards: source lookup, stall decision, allocation and stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
    parameter int unsigned ALU_LAT  = ALU_LAT_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    hazard_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:0]    busy;
    logic [NUM_REGS-1:0]    pending;
    logic [CNT_W-1:0]       lat;
    logic                   rs1_hit;
    logic                   rs2_hit;
    logic                   stall_c;
    logic                   accept_c;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // x0 is hardwired and never tracked.
    assign busy[0]    = 1'b0;
    assign pending[0] = 1'b0;

    // Source lookups, stall reduction and allocation qualifier; flush overrides everything.
    always_comb begin
        rs1_hit  = sb.rs1_used_i && (sb.rs1_i != '0) && busy[sb.rs1_i];
        rs2_hit  = sb.rs2_used_i && (sb.rs2_i != '0) && busy[sb.rs2_i];
        stall_c  = sb.issue_valid_i && !sb.flush_i && (rs1_hit || rs2_hit);
        accept_c = sb.issue_valid_i && !stall_c && !sb.flush_i &&
                   sb.reg_write_i && (sb.rd_i != '0);
        lat      = fwd_lat(sb.jal_i, sb.load_i, LOAD_LAT, ALU_LAT);
    end

    // One entry per architectural register except x0.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry u_entry (
            .clk     (clk_i),
            .rst     (reset_i),
            .alloc   (accept_c && (sb.rd_i == REG_ADDR_W'(r))),
            .lat     (lat),
            .wb_clr  (sb.wb_valid_i && (sb.wb_rd_i == REG_ADDR_W'(r))),
            .busy    (busy[r]),
            .pending (pending[r])
        );
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            stall_cnt <= '0;
        else if (stall_c && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end

    assign sb.stall_o     = stall_c;
    assign sb.pending_o   = pending;
    assign sb.stall_cnt_o = stall_cnt;

endmodule
